// File: rtl/sequence_detector_pkg.sv
// rtl/sequence_detector_pkg.sv - shared types and default sizes for the sequence detector
// Purpose: FSM state encoding and default SEQ_W / LOSS_THRESH / CNT_W values.
//          The sequence generator uses the same SEQ_W so both ends agree on the period.
// Ports:   none (package)
package seq_det_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int SEQ_W_DEF       = 16;
  localparam int LOSS_THRESH_DEF = 3;
  localparam int CNT_W_DEF       = 8;

endpackage

// File: rtl/sequence_detector_if.sv
// rtl/sequence_detector_if.sv - stream/status bundle between the input pin and the detector
// Purpose: groups the serial input, the programmed pattern and the status outputs.
//          Optional err_clr exists only when SEQ_DET_ERR_CLR_EN is defined.
// Ports (signals):
//   seq_in     serial bit, MSB of pattern first
//   seqence    pattern to detect (quasi-static)
//   match      one-cycle pulse when the window equals the pattern
//   locked     high while locked
//   LED_locked copy of locked for the board LED
//   err_cnt    saturating bit-error count
//   err_clr    (SEQ_DET_ERR_CLR_EN only) synchronous clear of err_cnt
// Modports: master = stimulus side, slave = detector side.
interface sequence_detector_if
  import seq_det_pkg::*;
#(
  parameter int SEQ_W = SEQ_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) ();

  logic             seq_in;
  logic [SEQ_W-1:0] seqence;
  logic             match;
  logic             locked;
  logic             LED_locked;
  logic [CNT_W-1:0] err_cnt;
`ifdef SEQ_DET_ERR_CLR_EN
  logic             err_clr;

  modport master (
    output seq_in, seqence, err_clr,
    input  match, locked, LED_locked, err_cnt
  );

  modport slave (
    input  seq_in, seqence, err_clr,
    output match, locked, LED_locked, err_cnt
  );
`else
  modport master (
    output seq_in, seqence,
    input  match, locked, LED_locked, err_cnt
  );

  modport slave (
    input  seq_in, seqence,
    output match, locked, LED_locked, err_cnt
  );
`endif

endinterface

// File: rtl/sequence_detector_window.sv
// rtl/sequence_detector_window.sv - sliding bit window, fill counter and pattern compare
// Purpose: shifts one bit per clock and flags when the window including the bit
//          being sampled now equals the pattern, once enough bits have arrived.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   seq_in      serial input bit
//   pat         registered pattern to compare against
//   cmp         combinational hit for the current edge
module seq_det_window
  import seq_det_pkg::*;
#(
  parameter int SEQ_W = SEQ_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seq_in,
  input  logic [SEQ_W-1:0] pat,
  output logic             cmp
);

  localparam int FILL_W = $clog2(SEQ_W + 1);

  // Only the newest SEQ_W-1 bits need storing: the compare always appends
  // the bit being sampled, so the oldest window bit would never be read.
  logic [SEQ_W-2:0]  win_q;
  logic [FILL_W-1:0] fill_q;
  logic [SEQ_W-1:0]  win_next;

  assign win_next = {win_q, seq_in};
  assign cmp      = (win_next == pat) && (fill_q >= FILL_W'(SEQ_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q  <= '0;
      fill_q <= '0;
    end else begin
      win_q <= win_next[SEQ_W-2:0];
      if (fill_q != FILL_W'(SEQ_W)) begin
        fill_q <= fill_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sequence_detector.sv
// rtl/sequence_detector.sv - serial test-sequence receiver with lock, error count and loss detect
// Purpose: searches the input stream for the programmed pattern, locks to its period,
//          checks each later bit against the expected rotation, counts errors and drops
//          lock after LOSS_THRESH consecutive misses. Optional err_clr input is enabled by
//          the SEQ_DET_ERR_CLR_EN macro.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    sequence_detector_if.slave: seq_in, seqence, match, locked, LED_locked,
//          err_cnt (and err_clr when SEQ_DET_ERR_CLR_EN is defined)
module sequence_detector
  import seq_det_pkg::*;
#(
  parameter int SEQ_W       = SEQ_W_DEF,
  parameter int LOSS_THRESH = LOSS_THRESH_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  sequence_detector_if.slave  bus
);

  localparam int MISS_W = $clog2(SEQ_W + 1);

  state_t            state_q;
  logic [SEQ_W-1:0]  pat_q;
  logic [SEQ_W-1:0]  exp_q;
  logic [MISS_W-1:0] miss_q;
  logic [MISS_W-1:0] miss_inc;
  logic [CNT_W-1:0]  err_cnt_q;
  logic              match_q;
  logic              locked_q;
  logic              led_q;
  logic              cmp;
  logic              pat_chg;
  logic              bit_ok;

  seq_det_window #(
    .SEQ_W (SEQ_W)
  ) u_window (
    .clk    (clk),
    .rst_n  (rst_n),
    .seq_in (bus.seq_in),
    .pat    (pat_q),
    .cmp    (cmp)
  );

  // A pattern change wins over everything on the edge it is seen; cmp still
  // refers to the old pattern then, so its hit is discarded.
  assign pat_chg  = (bus.seqence != pat_q);
  assign bit_ok   = (bus.seq_in == exp_q[SEQ_W-1]);
  assign miss_inc = miss_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SEARCH;
      pat_q     <= '0;
      exp_q     <= '0;
      miss_q    <= '0;
      err_cnt_q <= '0;
      match_q   <= 1'b0;
      locked_q  <= 1'b0;
      led_q     <= 1'b0;
    end else begin
      pat_q   <= bus.seqence;
      match_q <= cmp && !pat_chg;

      case (state_q)
        SEARCH: begin
          miss_q <= '0;
          if (cmp && !pat_chg) begin
            state_q  <= LOCKED;
            exp_q    <= pat_q;
            locked_q <= 1'b1;
            led_q    <= 1'b1;
          end
        end

        LOCKED: begin
          if (pat_chg) begin
            state_q  <= SEARCH;
            miss_q   <= '0;
            locked_q <= 1'b0;
            led_q    <= 1'b0;
          end else begin
            exp_q <= {exp_q[SEQ_W-2:0], exp_q[SEQ_W-1]};
            if (bit_ok) begin
              miss_q <= '0;
            end else begin
              if (!(&err_cnt_q)) begin
                err_cnt_q <= err_cnt_q + 1'b1;
              end
              // The error on the loss edge is still counted above.
              if (miss_inc == MISS_W'(LOSS_THRESH)) begin
                state_q  <= SEARCH;
                miss_q   <= '0;
                locked_q <= 1'b0;
                led_q    <= 1'b0;
              end else begin
                miss_q <= miss_inc;
              end
            end
          end
        end

        default: state_q <= SEARCH;
      endcase

`ifdef SEQ_DET_ERR_CLR_EN
      // Placed last so a clear overrides an increment on the same edge.
      if (bus.err_clr) begin
        err_cnt_q <= '0;
      end
`endif
    end
  end

  assign bus.match      = match_q;
  assign bus.locked     = locked_q;
  assign bus.LED_locked = led_q;
  assign bus.err_cnt    = err_cnt_q;

endmodule
